icache: RTL

- Direct-mapped, read-only instruction cache that answers the pipeline's instruction-fetch requests on the datapath_cache_if instruction side (imemREN/imemaddr in, ihit/imemload out).
- On a miss it fetches one word from the memory controller (iREN/iaddr out, iwait/iload in) and fills the line.
- Sits between the datapath and the memory arbiter; holds no dirty state.

---
 rtl/icache.sv | 100 ++++++++++
 1 files changed

// File: rtl/icache.sv
// icache: direct-mapped, read-only, one-word-per-line instruction cache.
// A hit is answered combinationally in IDLE; a miss goes to FETCH, holds a
// single-word read to the memory controller and fills the line on the edge
// where iwait drops. flush, imemREN dropping or reset abandon the fetch.
module icache #(
  parameter int SETS  = 16,
  parameter int IDX_W = $clog2(SETS),
  parameter int TAG_W = 30 - IDX_W
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        imemREN,
  input  logic [31:0] imemaddr,
  output logic        ihit,
  output logic [31:0] imemload,
  input  logic        flush,
  output logic        iREN,
  output logic [31:0] iaddr,
  input  logic        iwait,
  input  logic [31:0] iload
);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t            state_reg, state_next;
  logic [SETS-1:0]   valid_reg;
  logic [TAG_W-1:0]  tag_mem  [SETS];
  logic [31:0]       data_mem [SETS];

  logic [IDX_W-1:0]  idx;
  logic [TAG_W-1:0]  tag;
  logic              hit;
  logic              fill;
  logic              unused_offset;

  assign idx = imemaddr[IDX_W+1:2];
  assign tag = imemaddr[31:IDX_W+2];
  // Byte offset within the word is irrelevant to a word-wide fetch.
  assign unused_offset = ^imemaddr[1:0];

  // Tag compare is only meaningful while idle; in FETCH the line is being refilled.
  assign hit = (state_reg == IDLE) && imemREN && valid_reg[idx] && (tag_mem[idx] == tag);

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  // Next-state and output decode; a fill only happens on an undisturbed completion.
  always_comb begin
    state_next = state_reg;
    ihit       = 1'b0;
    imemload   = 32'd0;
    iREN       = 1'b0;
    iaddr      = 32'd0;
    fill       = 1'b0;
    case (state_reg)
      IDLE: begin
        if (hit) begin
          ihit     = !flush;
          imemload = data_mem[idx];
        end else if (imemREN) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (!imemREN || flush) begin
          state_next = IDLE;
        end else begin
          iREN  = 1'b1;
          iaddr = {imemaddr[31:2], 2'b00};
          if (!iwait) begin
            fill       = 1'b1;
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Per-line valid bits: flush wins over a same-edge fill.
  for (genvar gi = 0; gi < SETS; gi++) begin : g_valid
    always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST)                                 valid_reg[gi] <= 1'b0;
      else if (flush)                            valid_reg[gi] <= 1'b0;
      else if (fill && (idx == IDX_W'(gi)))      valid_reg[gi] <= 1'b1;
    end
  end

  // Tag and data storage; contents are don't-care until the valid bit is set.
  always_ff @(posedge CLK) begin
    if (fill) begin
      tag_mem[idx]  <= tag;
      data_mem[idx] <= iload;
    end
  end

endmodule
